// File: rtl/io_periph_pkg.sv
// Shared definitions for the io_periph_resp register window: offsets, CTRL/STATUS bits, FSM states.
// The timer offsets are only decoded when IO_PERIPH_TIMER_EN is defined.
package io_periph_pkg;

  localparam int unsigned IOP_WIN_SIZE = 32;

  localparam logic [4:0] IOP_SCRATCH0    = 5'h00;
  localparam logic [4:0] IOP_SCRATCH1    = 5'h04;
  localparam logic [4:0] IOP_MTIME_LO    = 5'h08;
  localparam logic [4:0] IOP_MTIME_HI    = 5'h0C;
  localparam logic [4:0] IOP_MTIMECMP_LO = 5'h10;
  localparam logic [4:0] IOP_MTIMECMP_HI = 5'h14;
  localparam logic [4:0] IOP_CTRL        = 5'h18;
  localparam logic [4:0] IOP_STATUS      = 5'h1C;

  localparam int unsigned IOP_CTRL_TMR_EN  = 0;
  localparam int unsigned IOP_CTRL_IRQ_EN  = 1;
  localparam int unsigned IOP_STATUS_PEND  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } IOP_STATE_T;

  // Offsets from MTIME_LO upward belong to the timer block.
  function automatic logic iop_is_timer_off(input logic [4:0] off);
    return off >= IOP_MTIME_LO;
  endfunction

endpackage

// File: rtl/io_mtimer.sv
// 64-bit machine timer with compare, sticky PEND (W1C) and registered interrupt output.
// Instantiated by io_periph_resp only when IO_PERIPH_TIMER_EN is defined.
module io_mtimer
  import io_periph_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        wr_en_i,
  input  logic [4:0]  off_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] rd_data_o,
  output logic        irq_o
);

  logic [63:0] mtime_q, mtime_d, mtime_inc;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;
  logic        hit;

  assign mtime_inc = mtime_q + 64'd1;
  assign hit       = (mtime_q >= mtimecmp_q);

  always_comb begin
    mtime_d    = ctrl_q[IOP_CTRL_TMR_EN] ? mtime_inc : mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    pend_d     = pend_q;
    if (wr_en_i) begin
      // A half-write overrides that half of the increment and suppresses any carry across.
      unique case (off_i)
        IOP_MTIME_LO:    mtime_d           = {mtime_q[63:32], wr_data_i};
        IOP_MTIME_HI:    mtime_d[63:32]    = wr_data_i;
        IOP_MTIMECMP_LO: mtimecmp_d[31:0]  = wr_data_i;
        IOP_MTIMECMP_HI: mtimecmp_d[63:32] = wr_data_i;
        IOP_CTRL:        ctrl_d            = wr_data_i[1:0];
        IOP_STATUS:      if (wr_data_i[IOP_STATUS_PEND]) pend_d = 1'b0;
        default:         ;
      endcase
    end
    if (hit) pend_d = 1'b1;
    irq_d = pend_q & ctrl_q[IOP_CTRL_IRQ_EN];
  end

  always_comb begin
    rd_data_o = '0;
    unique case (off_i)
      IOP_MTIME_LO:    rd_data_o = mtime_q[31:0];
      IOP_MTIME_HI:    rd_data_o = mtime_q[63:32];
      IOP_MTIMECMP_LO: rd_data_o = mtimecmp_q[31:0];
      IOP_MTIMECMP_HI: rd_data_o = mtimecmp_q[63:32];
      IOP_CTRL:        rd_data_o = {30'd0, ctrl_q};
      IOP_STATUS:      rd_data_o = {31'd0, pend_q};
      default:         rd_data_o = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      ctrl_q     <= '0;
      pend_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      pend_q     <= pend_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/io_periph_resp.sv
// Responder for the core's io_req/io_ack interface: scratch registers plus an optional machine timer.
// Define IO_PERIPH_TIMER_EN to build the timer (MTIME/MTIMECMP/CTRL/STATUS) and drive ext_irq.
module io_periph_resp
  import io_periph_pkg::*;
#(
  parameter int unsigned       A_SZ      = 32,
  parameter logic [A_SZ-1:0]   BASE_ADDR = A_SZ'(32'hFFFF_0000),
  parameter int unsigned       ACK_LAT   = 2
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            io_req,
  input  logic [A_SZ-1:0] io_addr,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [31:0]     io_wr_data,
  output logic            io_ack,
  output logic            io_ack_fault,
  output logic [31:0]     io_rd_data,
  output logic            ext_irq
);

  localparam int unsigned WIN_LSB = $clog2(IOP_WIN_SIZE);

  IOP_STATE_T      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [A_SZ-1:0] addr_q, addr_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            ack_q, ack_d;
  logic            fault_q, fault_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     scratch0_q, scratch0_d;
  logic [31:0]     scratch1_q, scratch1_d;

  logic [4:0]      off;
  logic            in_win;
  logic            bad_align;
  logic            bad_dir;
  logic            acc_fault;
  logic [31:0]     reg_rdata;
  logic            commit_wr;

  // Decode of the latched request, evaluated while in WAIT.
  assign off       = addr_q[WIN_LSB-1:0];
  assign in_win    = (addr_q[A_SZ-1:WIN_LSB] == BASE_ADDR[A_SZ-1:WIN_LSB]);
  assign bad_align = (addr_q[1:0] != 2'b00);
  assign bad_dir   = (rd_q == wr_q);

`ifdef IO_PERIPH_TIMER_EN
  logic [31:0] tmr_rdata;

  assign acc_fault = !in_win || bad_align || bad_dir;

  io_mtimer u_mtimer (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .wr_en_i   (commit_wr),
    .off_i     (off),
    .wr_data_i (wdata_q),
    .rd_data_o (tmr_rdata),
    .irq_o     (ext_irq)
  );
`else
  assign acc_fault = !in_win || bad_align || bad_dir || iop_is_timer_off(off);
  assign ext_irq   = 1'b0;
`endif

  always_comb begin
    reg_rdata = '0;
    unique case (off)
      IOP_SCRATCH0: reg_rdata = scratch0_q;
      IOP_SCRATCH1: reg_rdata = scratch1_q;
`ifdef IO_PERIPH_TIMER_EN
      default:      reg_rdata = tmr_rdata;
`else
      default:      reg_rdata = '0;
`endif
    endcase
  end

  // ack_q is only ever set for a fault-free request, so it qualifies the write.
  assign commit_wr = (state_q == RESP) && ack_q && wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    fault_d = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (io_req) begin
          addr_d  = io_addr;
          rd_d    = io_rd;
          wr_d    = io_wr;
          wdata_d = io_wr_data;
          cnt_d   = 4'(ACK_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          ack_d   = !acc_fault;
          fault_d = acc_fault;
          rdata_d = (acc_fault || !rd_q) ? 32'd0 : reg_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = DONE;
      DONE: begin
        if (!io_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    if (commit_wr && (off == IOP_SCRATCH0)) scratch0_d = wdata_q;
    if (commit_wr && (off == IOP_SCRATCH1)) scratch1_d = wdata_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      fault_q    <= 1'b0;
      rdata_q    <= '0;
      scratch0_q <= '0;
      scratch1_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
    end
  end

  assign io_ack       = ack_q;
  assign io_ack_fault = fault_q;
  assign io_rd_data   = rdata_q;

endmodule
